// File: rtl/iomem_router_pkg.sv
// Shared types and defaults for the iomem slot router.
package iomem_router_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StResp
  } state_e;

  localparam int unsigned SLOT_W            = 4;
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hFFFF_FFFF;
  localparam logic [7:0]  REGION_DEFAULT    = 8'h03;

endpackage

// File: rtl/iomem_timeout_ctr.sv
// Cycle counter that flags the LIMIT-th consecutive enabled cycle since the last clear.
module iomem_timeout_ctr #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Count holds LIMIT-1 during the LIMIT-th waiting cycle.
  assign expired = en && (cnt_q == 16'(LIMIT - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/iomem_router.sv
// Routes the PicoSoC iomem bus to one of NUM_SLOTS peripheral slots in a single address region.
// Optional watchdog on hung slots: define IOMEM_ROUTER_TIMEOUT_EN.
module iomem_router
  import iomem_router_pkg::*;
#(
  parameter int unsigned NUM_SLOTS      = 4,
  parameter logic [7:0]  REGION         = REGION_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    iomem_valid,
  output logic                    iomem_ready,
  input  logic [3:0]              iomem_wstrb,
  input  logic [31:0]             iomem_addr,
  input  logic [31:0]             iomem_wdata,
  output logic [31:0]             iomem_rdata,
  output logic [NUM_SLOTS-1:0]    s_valid,
  input  logic [NUM_SLOTS-1:0]    s_ready,
  output logic [3:0]              s_wstrb,
  output logic [31:0]             s_addr,
  output logic [31:0]             s_wdata,
  input  logic [32*NUM_SLOTS-1:0] s_rdata,
  input  logic                    err_clr,
  output logic                    err,
  output logic [31:0]             err_addr
);

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [31:0]       err_addr_q, err_addr_d;

  logic              sel_ready;
  logic [31:0]       sel_rdata;
  logic              accept;
  logic              new_err;
  logic              ctr_en;
  logic              expired;

  // Slot mux and one-hot request; slot_q is always mapped while ACTIVE.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    s_valid   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_q == SLOT_W'(i)) begin
        sel_ready  = s_ready[i];
        sel_rdata  = s_rdata[32*i +: 32];
        s_valid[i] = (state_q == StActive);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    err_addr_d = err_addr_q;
    accept     = 1'b0;
    new_err    = 1'b0;
    ctr_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (iomem_valid && !iomem_ready && (iomem_addr[31:24] == REGION)) begin
          accept  = 1'b1;
          addr_d  = iomem_addr;
          wdata_d = iomem_wdata;
          wstrb_d = iomem_wstrb;
          slot_d  = iomem_addr[23:20];
          if (32'(iomem_addr[23:20]) < NUM_SLOTS) begin
            state_d = StActive;
          end else begin
            new_err    = 1'b1;
            err_addr_d = iomem_addr;
            state_d    = StResp;
          end
        end
      end
      StActive: begin
        ctr_en = !sel_ready;
        if (sel_ready) begin
          rdata_d = sel_rdata;
          state_d = StResp;
        end else if (expired) begin
          new_err    = 1'b1;
          err_addr_d = addr_q;
          state_d    = StResp;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (new_err) begin
      rdata_d = ERR_RDATA;
    end
    // A new error outranks a simultaneous clear.
    err_d = err_q;
    if (new_err) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

`ifdef IOMEM_ROUTER_TIMEOUT_EN
  iomem_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk    (clk),
    .resetn (resetn),
    .clr    (accept),
    .en     (ctr_en),
    .expired(expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^{TIMEOUT_CYCLES, ctr_en};
  assign expired        = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      slot_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign iomem_ready = (state_q == StResp);
  assign iomem_rdata = rdata_q;
  assign s_addr      = addr_q;
  assign s_wdata     = wdata_q;
  assign s_wstrb     = wstrb_q;
  assign err         = err_q;
  assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_iomem_router.sv
// Directed bench for iomem_router: inputs driven and outputs checked on the falling edge.
module tb_iomem_router;

  localparam int unsigned NS = 4;

  logic           clk;
  logic           resetn;
  logic           iomem_valid;
  logic           iomem_ready;
  logic [3:0]     iomem_wstrb;
  logic [31:0]    iomem_addr;
  logic [31:0]    iomem_wdata;
  logic [31:0]    iomem_rdata;
  logic [NS-1:0]  s_valid;
  logic [NS-1:0]  s_ready;
  logic [3:0]     s_wstrb;
  logic [31:0]    s_addr;
  logic [31:0]    s_wdata;
  logic [32*NS-1:0] s_rdata;
  logic           err_clr;
  logic           err;
  logic [31:0]    err_addr;

  int total = 0;
  int bad   = 0;

  iomem_router #(
    .NUM_SLOTS     (NS),
    .REGION        (8'h03),
    .TIMEOUT_CYCLES(8),
    .ERR_RDATA     (32'hFFFF_FFFF)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .iomem_valid(iomem_valid),
    .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb),
    .iomem_addr (iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_wstrb    (s_wstrb),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_rdata    (s_rdata),
    .err_clr    (err_clr),
    .err        (err),
    .err_addr   (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn      = 1'b0;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    iomem_addr  = '0;
    iomem_wdata = '0;
    s_ready     = '0;
    s_rdata     = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'hCAFE_0000};
    err_clr     = 1'b0;

    @(negedge clk);
    check("rst_ready", 32'(iomem_ready), 32'd0);
    check("rst_rdata", iomem_rdata, 32'd0);
    check("rst_svalid", 32'(s_valid), 32'd0);
    check("rst_saddr", s_addr, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_erraddr", err_addr, 32'd0);
    resetn = 1'b1;

    // Read slot 1, ready in the first s_valid cycle.
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0310_0000;
    iomem_wstrb = 4'h0;
    @(negedge clk);
    check("t1_svalid", 32'(s_valid), 32'h2);
    check("t1_ready_early", 32'(iomem_ready), 32'd0);
    s_ready = 4'b0010;
    @(negedge clk);
    check("t1_ready", 32'(iomem_ready), 32'd1);
    check("t1_rdata", iomem_rdata, 32'h1234_5678);
    check("t1_svalid_off", 32'(s_valid), 32'd0);
    iomem_valid = 1'b0;
    s_ready     = '0;
    @(negedge clk);
    check("t1_ready_pulse", 32'(iomem_ready), 32'd0);

    // Write slot 2, ready in the fifth s_valid cycle; request fields must stay latched.
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0320_0004;
    iomem_wdata = 32'hA5A5_A5A5;
    iomem_wstrb = 4'b0011;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("t2_svalid", 32'(s_valid), 32'h4);
      check("t2_saddr", s_addr, 32'h0320_0004);
      check("t2_swdata", s_wdata, 32'hA5A5_A5A5);
      check("t2_swstrb", 32'(s_wstrb), 32'h3);
      check("t2_ready_early", 32'(iomem_ready), 32'd0);
      if (k == 1) begin
        iomem_wdata = 32'h0;
        iomem_wstrb = 4'hF;
      end
      if (k == 5) s_ready = 4'b0100;
    end
    @(negedge clk);
    check("t2_ready", 32'(iomem_ready), 32'd1);
    check("t2_rdata", iomem_rdata, 32'h2222_2222);
    iomem_valid = 1'b0;
    s_ready     = '0;
    @(negedge clk);
    check("t2_ready_pulse", 32'(iomem_ready), 32'd0);
    check("t2_err", 32'(err), 32'd0);

    // Unmapped slot 7: immediate error response.
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0370_0000;
    iomem_wstrb = 4'hF;
    @(negedge clk);
    check("t3_ready", 32'(iomem_ready), 32'd1);
    check("t3_rdata", iomem_rdata, 32'hFFFF_FFFF);
    check("t3_err", 32'(err), 32'd1);
    check("t3_erraddr", err_addr, 32'h0370_0000);
    check("t3_svalid", 32'(s_valid), 32'd0);
    iomem_valid = 1'b0;
    @(negedge clk);
    check("t3_ready_pulse", 32'(iomem_ready), 32'd0);

    // Clear coinciding with a new error: set wins.
    iomem_valid = 1'b1;
    iomem_addr  = 32'h03F0_0010;
    err_clr     = 1'b1;
    @(negedge clk);
    check("t4_err_set_wins", 32'(err), 32'd1);
    check("t4_erraddr", err_addr, 32'h03F0_0010);
    iomem_valid = 1'b0;
    err_clr     = 1'b0;
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t4_err_cleared", 32'(err), 32'd0);
    check("t4_erraddr_kept", err_addr, 32'h03F0_0010);

    // Async reset while ACTIVE.
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0330_0000;
    iomem_wstrb = 4'h0;
    @(negedge clk);
    check("t5_svalid", 32'(s_valid), 32'h8);
    #2 resetn = 1'b0;
    #1;
    check("t5_async_svalid", 32'(s_valid), 32'd0);
    check("t5_async_ready", 32'(iomem_ready), 32'd0);
    iomem_valid = 1'b0;
    @(negedge clk);
    check("t5_erraddr_rst", err_addr, 32'd0);
    resetn = 1'b1;
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0300_0008;
    s_ready     = 4'b0001;
    @(negedge clk);
    check("t5_svalid0", 32'(s_valid), 32'h1);
    @(negedge clk);
    check("t5_ready", 32'(iomem_ready), 32'd1);
    check("t5_rdata", iomem_rdata, 32'hCAFE_0000);
    iomem_valid = 1'b0;
    s_ready     = '0;
    @(negedge clk);

    // Outside the region: never answered.
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0200_0000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t6_no_ready", 32'(iomem_ready), 32'd0);
      check("t6_no_svalid", 32'(s_valid), 32'd0);
    end
    iomem_valid = 1'b0;
    @(negedge clk);

`ifdef IOMEM_ROUTER_TIMEOUT_EN
    // Slot 0 never ready: 8 cycles of s_valid then an error.
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0300_0040;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("t7_svalid", 32'(s_valid), 32'h1);
      check("t7_ready_early", 32'(iomem_ready), 32'd0);
    end
    @(negedge clk);
    check("t7_ready", 32'(iomem_ready), 32'd1);
    check("t7_rdata", iomem_rdata, 32'hFFFF_FFFF);
    check("t7_err", 32'(err), 32'd1);
    check("t7_erraddr", err_addr, 32'h0300_0040);
    iomem_valid = 1'b0;
    err_clr     = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    // Ready in the final allowed cycle wins.
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0300_0044;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("t8_svalid", 32'(s_valid), 32'h1);
      if (k == 8) s_ready = 4'b0001;
    end
    @(negedge clk);
    check("t8_ready", 32'(iomem_ready), 32'd1);
    check("t8_rdata", iomem_rdata, 32'hCAFE_0000);
    check("t8_err", 32'(err), 32'd0);
    iomem_valid = 1'b0;
    s_ready     = '0;
    @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
